// File: rtl/rbp_reader.sv
// rtl/rbp_reader.sv - rbp link initiator: session FSM, four-phase read handshake, output FIFO
// Optional read timeout enabled by defining RBP_RD_TIMEOUT_EN.
module rbp_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rbp_req,
  output logic        rbp_rst,
  output logic [3:0]  rbp_cmd,
  output logic        rbp_dat,
  input  logic        rbp_ack,
  input  logic [15:0] rbp_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] CMD_CLR = 4'h0;
  localparam logic [3:0] CMD_RD  = 4'h1;

  typedef enum logic [3:0] {
    IDLE, LRST, CLR_REQ, CLR_REL, RD_WAIT, RD_REQ, RD_REL, FIN, ABRT
  } state_t;

  state_t        state;
  logic [15:0]   remaining;
  logic          rst_cnt;
  logic [AW:0]   fifo_count;
  logic [AW:0]   count_n;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic [15:0]   mem [FIFO_DEPTH];
  logic          start_acc;
  logic          stop;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          tmo;

  assign rbp_dat   = 1'b0;
  assign start_acc = (state == IDLE) && start;
  // ABRT is excluded so a held abort level cannot stretch the link reset forever
  assign stop      = (state != IDLE) && (state != ABRT) && (abort || tmo);
  assign fifo_wr   = (state == RD_REQ) && rbp_req && rbp_ack && !stop;
  assign fifo_rd   = out_valid && out_ready;

`ifdef RBP_RD_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

  state_t     state_d;
  logic [9:0] timer;
  logic       timed;

  assign timed = state inside {CLR_REQ, CLR_REL, RD_REQ, RD_REL};
  assign tmo   = timed && (state == state_d) && (timer == TMO_LIMIT);

  // timer holds the number of cycles spent in the current state
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_d <= IDLE;
      timer   <= '0;
    end else begin
      state_d <= state;
      if (!timed)
        timer <= '0;
      else if (state != state_d)
        timer <= 10'd1;
      else if (timer != TMO_LIMIT)
        timer <= timer + 10'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      remaining <= '0;
      rst_cnt   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rbp_req   <= 1'b0;
      rbp_rst   <= 1'b0;
      rbp_cmd   <= CMD_CLR;
    end else begin
      done <= 1'b0;
      if (stop) begin
        rbp_req <= 1'b0;
        rbp_rst <= 1'b1;
        rst_cnt <= 1'b0;
        state   <= ABRT;
        if (tmo)
          err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              remaining <= word_count;
              err       <= 1'b0;
              busy      <= 1'b1;
              rbp_rst   <= 1'b1;
              rst_cnt   <= 1'b0;
              state     <= LRST;
            end
          end
          LRST: begin
            if (rst_cnt) begin
              rbp_rst <= 1'b0;
              state   <= CLR_REQ;
            end else begin
              rst_cnt <= 1'b1;
            end
          end
          // req rises one cycle after entry; ack is only honoured while req is high
          CLR_REQ: begin
            if (!rbp_req) begin
              rbp_req <= 1'b1;
              rbp_cmd <= CMD_CLR;
            end else if (rbp_ack) begin
              rbp_req <= 1'b0;
              state   <= CLR_REL;
            end
          end
          CLR_REL, RD_REL: begin
            if (!rbp_ack)
              state <= (remaining == '0) ? FIN : RD_WAIT;
          end
          RD_WAIT: begin
            if (!fifo_count[AW] && (remaining != '0))
              state <= RD_REQ;
          end
          RD_REQ: begin
            if (!rbp_req) begin
              rbp_req <= 1'b1;
              rbp_cmd <= CMD_RD;
            end else if (rbp_ack) begin
              remaining <= remaining - 16'd1;
              rbp_req   <= 1'b0;
              state     <= RD_REL;
            end
          end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          ABRT: begin
            if (rst_cnt) begin
              rbp_rst <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              rst_cnt <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (fifo_wr)
      mem[wr_ptr] <= rbp_data;
  end

  always_comb begin
    rd_ptr_n = rd_ptr + {{(AW-1){1'b0}}, fifo_rd};
    count_n  = fifo_count + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_rd};
  end

  // out_data is a registered copy of the head; a write into an emptying FIFO bypasses the array
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (start_acc) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      rd_ptr     <= rd_ptr_n;
      fifo_count <= count_n;
      out_valid  <= (count_n != '0);
      if (fifo_wr && ((fifo_count == '0) ||
                      ((fifo_count == {{AW{1'b0}}, 1'b1}) && fifo_rd)))
        out_data <= rbp_data;
      else
        out_data <= mem[rd_ptr_n];
    end
  end

endmodule

// File: tb/tb_rbp_reader.sv
// tb/tb_rbp_reader.sv - scoreboard bench for rbp_reader with a two-cycle responder model
`timescale 1ns/1ps
module tb_rbp_reader;

  logic        sys_clk    = 1'b0;
  logic        sys_rst    = 1'b1;
  logic        start      = 1'b0;
  logic        abort      = 1'b0;
  logic [15:0] word_count = '0;
  logic        busy, done, err, rbp_req, rbp_rst, rbp_dat;
  logic [3:0]  rbp_cmd;
  logic        rbp_ack    = 1'b0;
  logic [15:0] rbp_data   = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready  = 1'b0;

  rbp_reader #(.FIFO_DEPTH(16), .TIMEOUT(1023)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .word_count(word_count), .busy(busy), .done(done), .err(err),
    .rbp_req(rbp_req), .rbp_rst(rbp_rst), .rbp_cmd(rbp_cmd), .rbp_dat(rbp_dat),
    .rbp_ack(rbp_ack), .rbp_data(rbp_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_err = 0;
  int rst_cyc = 0, clr_hs = 0, rd_hs = 0, done_cnt = 0, done_busy = 0;
  int valid_seen = 0, n_out = 0, rd_total = 0, rwait = 0;
  int rd_base = 0, mute_at = -1;
  int b_rst, b_clr, b_rd, b_done, b_dbusy, b_valid, b_out;
  logic        prev_req = 1'b0;
  logic [15:0] exp_w;
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor, consumer and responder, all acting on the falling edge
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        q.delete();
        rbp_ack  = 1'b0;
        rwait    = 0;
        prev_req = 1'b0;
      end else begin
        if (rbp_rst) rst_cyc++;
        if (done) begin
          done_cnt++;
          if (busy) done_busy++;
        end
        if (out_valid) valid_seen++;
        if (rbp_req && !prev_req) begin
          if (rbp_cmd == 4'h0) clr_hs++;
          else rd_hs++;
        end
        prev_req = rbp_req;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("sb_empty", 32'(out_data), 32'hffff_ffff);
          end else begin
            exp_w = q.pop_front();
            chk("sb_data", 32'(out_data), 32'(exp_w));
          end
          n_out++;
        end
        if (!rbp_req) begin
          rwait   = 0;
          rbp_ack = 1'b0;
        end else if (!rbp_ack) begin
          if (rbp_cmd == 4'h1 && (rd_total - rd_base) == mute_at) begin
            rwait = 0;
          end else if (rwait == 1) begin
            rbp_ack = 1'b1;
            if (rbp_cmd == 4'h1) begin
              rbp_data = 16'h1000 + 16'(rd_total - rd_base);
              q.push_back(rbp_data);
              rd_total++;
            end else begin
              rbp_data = 16'hbeef;
            end
          end else begin
            rwait++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic snap();
    b_rst = rst_cyc; b_clr = clr_hs; b_rd = rd_hs; b_done = done_cnt;
    b_dbusy = done_busy; b_valid = valid_seen; b_out = n_out;
  endtask

  task automatic do_start(input logic [15:0] wc);
    @(posedge sys_clk);
    #2;
    word_count = wc;
    start      = 1'b1;
    rd_base    = rd_total;
    @(posedge sys_clk);
    #1;
    chk("start_rst", 32'(rbp_rst), 1);
    chk("start_busy", 32'(busy), 1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (busy && i < limit) begin
      tick(1);
      i++;
    end
    chk("idle_bound", 32'(busy), 0);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_req", 32'(rbp_req), 0);
    chk("rst_rst", 32'(rbp_rst), 0);
    chk("rst_cmd", 32'(rbp_cmd), 0);
    chk("rst_dat", 32'(rbp_dat), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    sys_rst = 1'b0;
    tick(2);

    // Normal session, FIFO holds all five words until drained
    snap();
    out_ready = 1'b0;
    do_start(16'd5);
    wait_idle(300);
    chk("n_rst_cycles", rst_cyc - b_rst, 2);
    chk("n_clr_hs", clr_hs - b_clr, 1);
    chk("n_rd_hs", rd_hs - b_rd, 5);
    chk("n_done", done_cnt - b_done, 1);
    chk("n_done_busy", done_busy - b_dbusy, 0);
    chk("n_valid", 32'(out_valid), 1);
    chk("n_head", 32'(out_data), 32'h1000);
    chk("n_sb_depth", q.size(), 5);
    out_ready = 1'b1;
    tick(10);
    chk("n_out", n_out - b_out, 5);
    chk("n_empty", 32'(out_valid), 0);

    // Zero word count
    snap();
    do_start(16'd0);
    wait_idle(100);
    chk("z_rst_cycles", rst_cyc - b_rst, 2);
    chk("z_clr_hs", clr_hs - b_clr, 1);
    chk("z_rd_hs", rd_hs - b_rd, 0);
    chk("z_done", done_cnt - b_done, 1);
    chk("z_valid", valid_seen - b_valid, 0);

    // Backpressure: FIFO fills, reads stall, then resume in order
    snap();
    out_ready = 1'b0;
    do_start(16'd20);
    for (int i = 0; i < 600 && (rd_hs - b_rd) < 16; i++) tick(1);
    tick(40);
    chk("bp_stall_reads", rd_hs - b_rd, 16);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_req", 32'(rbp_req), 0);
    chk("bp_head", 32'(out_data), 32'h1000);
    out_ready = 1'b1;
    wait_idle(600);
    tick(25);
    chk("bp_reads", rd_hs - b_rd, 20);
    chk("bp_out", n_out - b_out, 20);
    chk("bp_done", done_cnt - b_done, 1);
    chk("bp_empty", 32'(out_valid), 0);

    // Abort while the third read request is outstanding; a start while busy is ignored
    snap();
    mute_at   = 2;
    out_ready = 1'b1;
    do_start(16'd5);
    @(posedge sys_clk);
    #2;
    word_count = 16'd9;
    start      = 1'b1;
    @(posedge sys_clk);
    #2;
    start = 1'b0;
    for (int i = 0; i < 300 && !((rd_hs - b_rd) == 3 && rbp_req); i++) tick(1);
    chk("ab_reach", rd_hs - b_rd, 3);
    abort = 1'b1;
    tick(1);
    chk("ab_req", 32'(rbp_req), 0);
    chk("ab_rst1", 32'(rbp_rst), 1);
    abort = 1'b0;
    tick(1);
    chk("ab_rst2", 32'(rbp_rst), 1);
    tick(1);
    chk("ab_rst_end", 32'(rbp_rst), 0);
    chk("ab_busy", 32'(busy), 0);
    tick(5);
    chk("ab_done", done_cnt - b_done, 0);
    chk("ab_rst_cycles", rst_cyc - b_rst, 4);
    chk("ab_out", n_out - b_out, 2);
    chk("ab_err", 32'(err), 0);
    mute_at = -1;

`ifdef RBP_RD_TIMEOUT_EN
    // Responder never acks the third read
    snap();
    mute_at = 2;
    do_start(16'd5);
    wait_idle(1500);
    chk("to_err", 32'(err), 1);
    chk("to_done", done_cnt - b_done, 0);
    chk("to_rst_cycles", rst_cyc - b_rst, 4);
    chk("to_out", n_out - b_out, 2);
    mute_at = -1;
    do_start(16'd0);
    chk("to_err_clear", 32'(err), 0);
    wait_idle(100);
`endif

    // Asynchronous reset in the middle of a session
    snap();
    out_ready = 1'b0;
    do_start(16'd5);
    for (int i = 0; i < 300 && !((rd_hs - b_rd) >= 2 && rbp_req); i++) tick(1);
    chk("ar_reach", 32'(rbp_req), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("ar_req", 32'(rbp_req), 0);
    chk("ar_rst", 32'(rbp_rst), 0);
    chk("ar_cmd", 32'(rbp_cmd), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data", 32'(out_data), 0);
    @(negedge sys_clk);
    #1;
    sys_rst = 1'b0;
    tick(5);
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_req", 32'(rbp_req), 0);
    chk("ar_idle_valid", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
